// File: rtl/tank_pkg.sv
// Shared types for the tank pump controller: FSM state encodings, the
// packed sensor level vector and its physical-consistency check.
package tank_pkg;

  typedef enum logic [1:0] {
    ST_OFF_WAIT = 2'd0,
    ST_IDLE     = 2'd1,
    ST_FILL     = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // Bit 2 = high, bit 1 = medium, bit 0 = low (1 = water present).
  typedef logic [2:0] level_t;

  // Water above a sensor implies water at every sensor below it.
  function automatic logic level_valid(input level_t v);
    return (!v[2] || v[1]) && (!v[1] || v[0]);
  endfunction

endpackage

// File: rtl/tank_pump_controller_level_debouncer.sv
// Two-flop synchronizer plus hold-time debouncer for the 3-bit level vector.
// The stable register loads once the synchronized vector has held DEBOUNCE_CYCLES cycles.
module level_debouncer
  import tank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  level_t raw,
  output level_t stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  level_t          sync1;
  level_t          sync2;
  level_t          prev;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            changed;

  // cnt is the number of cycles the current sync2 value has been present,
  // counting the cycle in which it first appeared.
  always_comb begin
    changed  = (sync2 != prev);
    cnt_next = cnt;
    if (changed) begin
      cnt_next = CW'(1);
    end else if (cnt < CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      cnt    <= CW'(1);
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        stable <= sync2;
      end
    end
  end

endmodule

// File: rtl/tank_pump_controller.sv
// Fill-cycle controller: debounced tank levels drive an OFF_WAIT/IDLE/FILL/FAULT
// state machine with a minimum pump-off time and a fill timeout.
module tank_pump_controller
  import tank_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_OFF_CYCLES  = 1024,
  parameter int MAX_FILL_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       highLevel,
  input  logic       mediumLevel,
  input  logic       lowLevel,
  input  logic       fillRequest,
  input  logic       faultClear,
  output logic       pumpOn,
  output logic       alarm,
  output logic       stableHigh,
  output logic       stableMedium,
  output logic       stableLow,
  output logic [1:0] stateCode
);

  localparam int OW = $clog2(MIN_OFF_CYCLES + 1);
  localparam int FW = $clog2(MAX_FILL_CYCLES + 1);
  localparam logic [OW-1:0] OFF_MAX  = OW'(MIN_OFF_CYCLES);
  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_FILL_CYCLES);

  level_t        stable;
  logic          valid;
  state_t        state_reg;
  state_t        state_next;
  logic [OW-1:0] off_cnt;
  logic [OW-1:0] off_cnt_next;
  logic [FW-1:0] fill_cnt;
  logic [FW-1:0] fill_cnt_next;
  logic          off_done;
  logic          fill_done;

  level_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    ({highLevel, mediumLevel, lowLevel}),
    .stable (stable)
  );

  assign valid = level_valid(stable);

  // The limit is reached on the edge that would bring the timer to it.
  assign off_done  = (off_cnt == OFF_MAX - 1'b1);
  assign fill_done = (fill_cnt == FILL_MAX - 1'b1);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_OFF_WAIT: begin
        if (!valid)        state_next = ST_FAULT;
        else if (off_done) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!valid)                        state_next = ST_FAULT;
        else if (!stable[0])               state_next = ST_FILL;
        else if (fillRequest && !stable[1]) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (!valid)         state_next = ST_FAULT;
        else if (fill_done) state_next = ST_FAULT;
        else if (stable[2]) state_next = ST_OFF_WAIT;
      end
      ST_FAULT: begin
        if (faultClear && valid) state_next = ST_OFF_WAIT;
      end
      default: state_next = ST_OFF_WAIT;
    endcase
  end

  always_comb begin
    off_cnt_next  = off_cnt;
    fill_cnt_next = fill_cnt;
    if (state_next != state_reg) begin
      off_cnt_next  = '0;
      fill_cnt_next = '0;
    end else begin
      if (state_reg == ST_OFF_WAIT && off_cnt < OFF_MAX)
        off_cnt_next = off_cnt + 1'b1;
      if (state_reg == ST_FILL && fill_cnt < FILL_MAX)
        fill_cnt_next = fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_OFF_WAIT;
      off_cnt   <= '0;
      fill_cnt  <= '0;
      pumpOn    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_reg <= state_next;
      off_cnt   <= off_cnt_next;
      fill_cnt  <= fill_cnt_next;
      pumpOn    <= (state_next == ST_FILL);
      alarm     <= (state_next == ST_FAULT);
    end
  end

  assign stateCode    = state_reg;
  assign stableHigh   = stable[2];
  assign stableMedium = stable[1];
  assign stableLow    = stable[0];

endmodule
